// File: rtl/booth_route_pipe_if.sv
// Bundled data, tap and config signals of booth_route_pipe.
// master drives samples and config; slave is the router side.
interface booth_route_pipe_if #(
  parameter int N  = 32,
  parameter int SW = 3
);
  logic             in_valid;
  logic [N-1:0]     dn2;
  logic [N-1:0]     dp;
  logic [N-1:0]     dpp;
  logic             cfg_we;
  logic [SW-1:0]    cfg_stage;
  logic [N/2-1:0]   cfg_data;
  logic             cfg_commit;
  logic             cfg_ready;
  logic             out_valid;
  logic [N-1:0]     on2;
  logic [N-1:0]     op;
  logic [N-1:0]     opp;
  logic [N/2-1:0]   wn2;
  logic [N/2-1:0]   wp;
  logic [N/2-1:0]   wpp;
  logic             err;

  modport master (
    output in_valid, dn2, dp, dpp, cfg_we, cfg_stage, cfg_data, cfg_commit,
    input  cfg_ready, out_valid, on2, op, opp, wn2, wp, wpp, err
  );

  modport slave (
    input  in_valid, dn2, dp, dpp, cfg_we, cfg_stage, cfg_data, cfg_commit,
    output cfg_ready, out_valid, on2, op, opp, wn2, wp, wpp, err
  );
endinterface

// File: rtl/booth_route_pipe.sv
// STAGES-deep pipelined butterfly-shuffle router for Booth-digit lane triplets with a
// double-buffered, bank-tagged routing config. ROUTE_ONEHOT_CHK_EN adds input one-hot checking.
module booth_route_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 5,
  parameter int SW     = 3
) (
  input logic               clk,
  input logic               rst,
  booth_route_pipe_if.slave bus
);
  localparam int H  = N / 2;
  localparam int CW = $clog2(STAGES + 1);
  localparam int TW = (STAGES > 1) ? STAGES - 1 : 1;

  logic [H-1:0]  bank_q [2][STAGES];
  logic [H-1:0]  bank_d [2][STAGES];
  logic          activeBank_q, activeBank_d;
  logic [CW-1:0] drainCnt_q, drainCnt_d;

  logic          valid_q [STAGES];
  logic          valid_d [STAGES];
  logic          tag_q   [TW];
  logic          tag_d   [TW];
  logic [N-1:0]  n2_q    [STAGES];
  logic [N-1:0]  n2_d    [STAGES];
  logic [N-1:0]  p_q     [STAGES];
  logic [N-1:0]  p_d     [STAGES];
  logic [N-1:0]  pp_q    [STAGES];
  logic [N-1:0]  pp_d    [STAGES];
  logic [H-1:0]  tapN2_q [STAGES];
  logic [H-1:0]  tapN2_d [STAGES];
  logic [H-1:0]  tapP_q  [STAGES];
  logic [H-1:0]  tapP_d  [STAGES];
  logic [H-1:0]  tapPp_q [STAGES];
  logic [H-1:0]  tapPp_d [STAGES];

  logic          inValid [STAGES];
  logic          inTag   [STAGES];
  logic [N-1:0]  inN2    [STAGES];
  logic [N-1:0]  inP     [STAGES];
  logic [N-1:0]  inPp    [STAGES];
  logic [H-1:0]  inTapN2 [STAGES];
  logic [H-1:0]  inTapP  [STAGES];
  logic [H-1:0]  inTapPp [STAGES];

  logic [N-1:0]  srcN2, srcP, srcPp;
  logic          cfgReady, cfgWrite, cfgCommit;

  // Butterfly k pairs lane k with lane k+H; swap bit set sends the upper lane to the even slot.
  function automatic logic [N-1:0] shuffle(input logic [N-1:0] v, input logic [H-1:0] ctrl);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < H; k++) begin
      r[2*k]   = ctrl[k] ? v[k+H] : v[k];
      r[2*k+1] = ctrl[k] ? v[k]   : v[k+H];
    end
    return r;
  endfunction

`ifdef ROUTE_ONEHOT_CHK_EN
  logic [N-1:0] illegal;
  logic         err_q;

  assign illegal = {N{bus.in_valid}} &
                   ((bus.dn2 & bus.dp) | (bus.dn2 & bus.dpp) | (bus.dp & bus.dpp));
  assign srcN2   = bus.dn2 & ~illegal;
  assign srcP    = bus.dp  & ~illegal;
  assign srcPp   = bus.dpp & ~illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|illegal);
    end
  end

  assign bus.err = err_q;
`else
  assign srcN2   = bus.dn2;
  assign srcP    = bus.dp;
  assign srcPp   = bus.dpp;
  assign bus.err = 1'b0;
`endif

  // Writes and commits are held off while samples tagged with the old bank are still in flight.
  assign cfgReady  = (drainCnt_q == '0);
  assign cfgWrite  = bus.cfg_we && cfgReady && (int'(bus.cfg_stage) < STAGES);
  assign cfgCommit = bus.cfg_commit && cfgReady;

  always_comb begin
    bank_d = bank_q;
    if (cfgWrite) begin
      bank_d[~activeBank_q][bus.cfg_stage] = bus.cfg_data;
    end
    activeBank_d = activeBank_q ^ cfgCommit;
    if (cfgCommit) begin
      drainCnt_d = CW'(STAGES);
    end else if (drainCnt_q != '0) begin
      drainCnt_d = drainCnt_q - 1'b1;
    end else begin
      drainCnt_d = '0;
    end
  end

  always_comb begin
    inValid[0] = bus.in_valid;
    inTag[0]   = activeBank_q;
    inN2[0]    = srcN2;
    inP[0]     = srcP;
    inPp[0]    = srcPp;
    inTapN2[0] = srcN2[N-1:H];
    inTapP[0]  = srcP[N-1:H];
    inTapPp[0] = srcPp[N-1:H];
    for (int s = 1; s < STAGES; s++) begin
      inValid[s] = valid_q[s-1];
      inTag[s]   = tag_q[s-1];
      inN2[s]    = n2_q[s-1];
      inP[s]     = p_q[s-1];
      inPp[s]    = pp_q[s-1];
      inTapN2[s] = tapN2_q[s-1];
      inTapP[s]  = tapP_q[s-1];
      inTapPp[s] = tapPp_q[s-1];
    end
    for (int s = 0; s < TW; s++) begin
      tag_d[s] = 1'b0;
    end
    // Invalid slots load zeros so the outputs are clean whenever out_valid is low.
    for (int s = 0; s < STAGES; s++) begin
      valid_d[s] = inValid[s];
      if (s < STAGES - 1) begin
        tag_d[s] = inValid[s] & inTag[s];
      end
      n2_d[s]    = inValid[s] ? shuffle(inN2[s], bank_q[inTag[s]][s]) : '0;
      p_d[s]     = inValid[s] ? shuffle(inP[s],  bank_q[inTag[s]][s]) : '0;
      pp_d[s]    = inValid[s] ? shuffle(inPp[s], bank_q[inTag[s]][s]) : '0;
      tapN2_d[s] = inValid[s] ? inTapN2[s] : '0;
      tapP_d[s]  = inValid[s] ? inTapP[s]  : '0;
      tapPp_d[s] = inValid[s] ? inTapPp[s] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < STAGES; s++) begin
          bank_q[b][s] <= '0;
        end
      end
      activeBank_q <= 1'b0;
      drainCnt_q   <= '0;
    end else begin
      bank_q       <= bank_d;
      activeBank_q <= activeBank_d;
      drainCnt_q   <= drainCnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        n2_q[s]    <= '0;
        p_q[s]     <= '0;
        pp_q[s]    <= '0;
        tapN2_q[s] <= '0;
        tapP_q[s]  <= '0;
        tapPp_q[s] <= '0;
      end
      for (int s = 0; s < TW; s++) begin
        tag_q[s] <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      n2_q    <= n2_d;
      p_q     <= p_d;
      pp_q    <= pp_d;
      tapN2_q <= tapN2_d;
      tapP_q  <= tapP_d;
      tapPp_q <= tapPp_d;
    end
  end

  assign bus.cfg_ready = cfgReady;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.on2       = n2_q[STAGES-1];
  assign bus.op        = p_q[STAGES-1];
  assign bus.opp       = pp_q[STAGES-1];
  assign bus.wn2       = tapN2_q[STAGES-1];
  assign bus.wp        = tapP_q[STAGES-1];
  assign bus.wpp       = tapPp_q[STAGES-1];
endmodule

// File: doc/booth_route_pipe.md
Name: booth_route_pipe

Overview:
Pipelined, reconfigurable multi-stage routing network for Booth-digit lanes (n2/p/pp one-hot triplets) in the ACFIR stream processor. It is the successor to the single-stage butterfly routing map. It chains STAGES butterfly-shuffle stages, with one register per stage. Routing config is double-buffered, and every sample carries a bank tag so reconfiguration is glitch-free while data streams.

Parameters:
N, 32, lane count; power of two, >= 4
STAGES, 5, butterfly stages; default log2(N) gives a full omega network
SW, 3, cfg_stage index width; >= max(1, ceil(log2(STAGES)))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
dn2  in  N  per-lane Booth digit -2 flag
dp  in  N  per-lane Booth digit +1 flag
dpp  in  N  per-lane Booth digit +2 flag
cfg_we  in  1  write one stage row into the shadow (inactive) bank
cfg_stage  in  SW  stage index for cfg_we
cfg_data  in  N/2  one swap bit per butterfly for that stage
cfg_commit  in  1  pulse; swap active and shadow banks
cfg_ready  out  1  high when a config write or commit is accepted
out_valid  out  1  output sample valid
on2  out  N  routed -2 flags
op  out  N  routed +1 flags
opp  out  N  routed +2 flags
wn2  out  N/2  upper-half input dn2, delay-matched
wp  out  N/2  upper-half input dp, delay-matched
wpp  out  N/2  upper-half input dpp, delay-matched
err  out  1  sticky illegal-encoding flag (see Optional Feature)

Behaviour:
- Reset is asynchronous on rst high.
  - Clears: all stage registers, valid and bank-tag pipeline, both config banks (all zeros = identity), active bank = 0.
  - Outputs after reset: out_valid=0; on2/op/opp/wn2/wp/wpp=0; err=0; cfg_ready=1.
  - Reset mid-stream drops all in-flight samples. No output is produced for them.
- Stage s, butterfly k (k = 0..N/2-1):
  - Inputs: x = lane k, y = lane k+N/2 of the stage input. All three triplet bits are switched together.
  - ctrl = bank[tag][s][k].
  - ctrl 0: out[2k]=x, out[2k+1]=y.
  - ctrl 1: out[2k]=y, out[2k+1]=x.
- Each stage output is registered. Latency from in_valid to out_valid = STAGES cycles exactly.
- Throughput is 1 sample/cycle. There is no backpressure.
- Valid gating: a stage register loads zeros when its incoming valid is low. Outputs are therefore all-zero whenever out_valid=0.
- Bank tag:
  - Tag = active bank at the cycle the sample enters stage 0.
  - The tag travels with the sample. Each stage reads its own row from the tagged bank.
- Config writes: cfg_we && cfg_ready writes cfg_data into row cfg_stage of the inactive bank.
  - cfg_stage >= STAGES: write ignored.
  - cfg_we while cfg_ready=0: ignored.
- Commit: cfg_commit && cfg_ready flips the active bank. The first sample entering on the next cycle uses the new bank.
  - Same-cycle cfg_we + cfg_commit: the write lands first, then the bank flips. The written row is live.
- Drain after commit:
  - cfg_ready drops for STAGES cycles, until every sample tagged with the old bank has left.
  - It returns high on cycle commit+STAGES+1.
  - cfg_commit while cfg_ready=0: ignored.
- Tap outputs: wn2[j]/wp[j]/wpp[j] = input lane j+N/2, delayed STAGES cycles through registers. Same valid gating; aligned with on2/op/opp.

Optional Feature:
Macro ROUTE_ONEHOT_CHK_EN.
- Defined:
  - Input lanes with more than one of dn2/dp/dpp set, while in_valid=1, are illegal.
  - Illegal lanes are forced to 000 before stage 0.
  - err is set on the cycle after detection and stays set until rst.
- Undefined: no check; data passes unmodified; err tied to 0.

Test Plan:
- Reset, all-zero config, N=32: dp=32'h0000_0001, in_valid=1 for one cycle -> out_valid=1 at cycle 5, op=32'h0000_0001 (identity); wp=0; all outputs 0 otherwise.
- Write all rows 16'hFFFF, commit, drive dp lane i one-hot for i=0..31 -> op lane 31-i set, 5 cycles after each input.
- Streaming with commit at cycle 10:
  - samples entering <=10 route per old bank; samples entering >=11 route per new bank;
  - cfg_ready low for cycles 11..15, high at 16;
  - cfg_we at 12 ignored (bank readback via routing unchanged).
- Same-cycle cfg_we(stage 0, 16'h0001) + cfg_commit -> next sample: lanes 0 and 16 swapped at stage 0; tap wdpp = input dpp[31:16] delayed 5 cycles.
- rst asserted at cycle 3 of a 10-sample burst -> outputs 0 asynchronously, no out_valid from pre-reset samples, banks back to identity.
- With ROUTE_ONEHOT_CHK_EN: lane 4 dp=dpp=1 -> lane 4 routes as 000, err=1 next cycle and held; without the macro, both bits routed and err=0.
